mul_final_adder: RTL and testbench

- Carry-propagate stage directly downstream of the 16-row Wallace reduction tree in the PE multiplier.
- Accepts the tree's two 64-bit redundant rows (sum, carry; carry row already bit-aligned), resolves them with a 2-stage pipelined 64-bit adder, and selects the RISC-V M-extension result half per opcode.
- Uses a valid/ready handshake on both sides, with full throughput of one result per cycle and a flush for pipeline squash.

---
 rtl/mul_final_adder.sv | 67 ++++++
 tb/tb_mul_final_adder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_final_adder.sv
// mul_final_adder: two-stage pipelined carry-propagate adder that resolves the Wallace
// tree's sum/carry rows and selects the RV32M product half for the requested opcode.
module mul_final_adder #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_sum,
  input  logic [63:0]      in_carry,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);
  logic             a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [32:0]      lo_q, lo_d;
  logic [31:0]      sum_hi_q, sum_hi_d, carry_hi_q, carry_hi_d, result_q, result_d, hi;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d, tag_q, tag_d;
  logic             a_load, b_load;
  always_comb begin
    b_load     = !b_valid_q | out_ready;
    a_load     = !a_valid_q | b_load;
    in_ready   = a_load & !flush;
    hi         = sum_hi_q + carry_hi_q + {31'd0, lo_q[32]};
    b_valid_d  = flush ? 1'b0 : (b_load ? a_valid_q : b_valid_q);
    a_valid_d  = flush ? 1'b0 : (a_load ? in_valid & in_ready : a_valid_q);
    lo_d       = a_load ? {1'b0, in_sum[31:0]} + {1'b0, in_carry[31:0]} : lo_q;
    sum_hi_d   = a_load ? in_sum[63:32] : sum_hi_q;
    carry_hi_d = a_load ? in_carry[63:32] : carry_hi_q;
    op_d       = a_load ? in_op : op_q;
    a_tag_d    = a_load ? in_tag : a_tag_q;
    result_d   = b_load ? (op_q == 2'b00 ? lo_q[31:0] : hi) : result_q;
    tag_d      = b_load ? a_tag_q : tag_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      lo_q       <= '0;
      sum_hi_q   <= '0;
      carry_hi_q <= '0;
      op_q       <= '0;
      a_tag_q    <= '0;
      result_q   <= '0;
      tag_q      <= '0;
    end else begin
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      lo_q       <= lo_d;
      sum_hi_q   <= sum_hi_d;
      carry_hi_q <= carry_hi_d;
      op_q       <= op_d;
      a_tag_q    <= a_tag_d;
      result_q   <= result_d;
      tag_q      <= tag_d;
    end
  end
  assign out_valid  = b_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;
endmodule

// File: tb/tb_mul_final_adder.sv
// tb_mul_final_adder: random and directed traffic checked every cycle against a queue model
module tb_mul_final_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_sum = '0;
  logic [63:0] in_carry = '0;
  logic [1:0]  in_op = '0;
  logic [4:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  mul_final_adder #(.TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_op(in_op), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one 64-bit add, then pick the product half
  function automatic logic [31:0] ref_result(input logic [63:0] s, input logic [63:0] c,
                                             input logic [1:0] op);
    logic [63:0] p;
    p = s + c;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  typedef struct {
    logic [31:0] r;
    logic [4:0]  t;
    int          e0;
  } ent_t;

  ent_t q[$];
  int   e = 0;

  // An accepted op reaches the output two edges after its accept edge, or later if stalled
  function automatic logic exp_out_valid();
    return (q.size() > 0) && (e >= q[0].e0 + 2);
  endfunction

  function automatic logic exp_in_ready();
    return !flush && !(q.size() == 2 && !out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      logic ox, ix;
      ox = exp_out_valid() && out_ready;
      ix = in_valid && exp_in_ready();
      if (ox) void'(q.pop_front());
      if (flush) q.delete();
      else if (ix) q.push_back('{ref_result(in_sum, in_carry, in_op), in_tag, e});
      e++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, exp_in_ready());
      check("out_valid", out_valid, exp_out_valid());
      if (exp_out_valid()) begin
        check("out_result", out_result, q[0].r);
        check("out_tag", out_tag, q[0].t);
      end
    end
  end

  task automatic drive(input logic v, input logic [63:0] s, input logic [63:0] c,
                       input logic [1:0] op, input logic [4:0] t);
    in_valid = v;
    in_sum   = s;
    in_carry = c;
    in_op    = op;
    in_tag   = t;
  endtask

  task automatic drive_rand(input logic v, input logic [4:0] t);
    drive(v, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)), t);
  endtask

  // Single op into an empty pipe: literal result and two-cycle latency
  task automatic run_single(input string name, input logic [63:0] s, input logic [63:0] c,
                            input logic [1:0] op, input logic [4:0] t, input logic [31:0] lit);
    int n;
    logic got;
    logic [31:0] res;
    logic [4:0] tg;
    n = 0;
    got = 1'b0;
    @(negedge clk);
    #1;
    out_ready = 1'b1;
    flush = 1'b0;
    drive(1'b1, s, c, op, t);
    @(posedge clk);
    while (!got && n < 6) begin
      @(negedge clk);
      n++;
      got = out_valid;
      res = out_result;
      tg = out_tag;
      #1;
      in_valid = 1'b0;
    end
    check({name, " latency"}, 64'(n), 64'd2);
    check({name, " result"}, res, lit);
    check({name, " tag"}, tg, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, cnt;
    logic [31:0] held;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_result", out_result, 0);
    check("reset out_tag", out_tag, 0);
    check("reset in_ready", in_ready, 1);

    run_single("carry mulh", 64'h0000_0000_FFFF_FFFF, 64'h1, 2'b01, 5'd3, 32'h0000_0001);
    run_single("carry mul", 64'h0000_0000_FFFF_FFFF, 64'h1, 2'b00, 5'd3, 32'h0000_0000);
    run_single("wrap mulhu", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b11, 5'd9, 32'h0000_0000);
    run_single("mix mul", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 2'b00, 5'd4,
               32'hABCD_F001);
    repeat (2) @(negedge clk);

    first = -1;
    last = -1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
      if (i < 8) check("stream in_ready", in_ready, 1);
      #1;
      out_ready = 1'b1;
      if (i < 8) drive_rand(1'b1, 5'(i));
      else in_valid = 1'b0;
    end
    check("stream first", 64'(first), 64'd2);
    check("stream last", 64'(last), 64'd9);
    check("stream count", 64'(cnt), 64'd8);

    @(negedge clk);
    #1;
    drive_rand(1'b1, 5'd10);
    @(negedge clk);
    #1;
    drive_rand(1'b1, 5'd11);
    @(negedge clk);
    check("bp first result", out_valid, 1);
    #1;
    out_ready = 1'b0;
    drive_rand(1'b1, 5'd12);
    #1;
    check("bp in_ready low", in_ready, 0);
    held = out_result;
    repeat (4) begin
      @(negedge clk);
      check("bp stable", out_result, held);
      check("bp held in_ready", in_ready, 0);
    end
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("bp drained", out_valid, 0);

    @(negedge clk);
    #1;
    drive_rand(1'b1, 5'd20);
    @(negedge clk);
    #1;
    drive_rand(1'b1, 5'd21);
    @(negedge clk);
    #1;
    flush = 1'b1;
    drive_rand(1'b1, 5'd22);
    #1;
    check("flush in_ready", in_ready, 0);
    @(negedge clk);
    check("flush out_valid", out_valid, 0);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    run_single("post flush", 64'h0000_0001_0000_0002, 64'h0000_0003_FFFF_FFFF, 2'b10, 5'd23,
               32'h0000_0005);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      drive_rand($urandom_range(0, 3) != 0, 5'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 29) == 0;
    end
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("random drained", out_valid, 0);

    #1;
    out_ready = 1'b0;
    drive(1'b1, 64'h0000_00AA_0000_0055, 64'h0000_0011_0000_0022, 2'b00, 5'd30);
    @(negedge clk);
    #1;
    drive(1'b1, 64'h0000_00BB_0000_0066, 64'h0000_0001_0000_0001, 2'b01, 5'd31);
    @(negedge clk);
    check("pre-reset out_valid", out_valid, 1);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst out_result", out_result, 0);
    check("async rst out_tag", out_tag, 0);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    run_single("post reset", 64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 2'b11, 5'd17,
               32'h0000_0001);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
